ppu_arr: RTL and testbench
==========================

Name: ppu_arr

Overview:
- Post-processing unit array: the responder that consumes the per-lane operand bundles driven by the PPU array controller.
- Requantizes conv/pool/remap/fc accumulators (mode 0), or combines two scaled int8 operands for element-wise add (mode 1).
- Saturates results to uint8 and returns them with the opaque input tag, after a fixed latency.
- Sits between the array controller's operand registers and its output demux.

Parameters:
- N, 64 (`S*`R), number of lanes.
- TAG_W, 8, width of the opaque tag.
- LAT, 6, fixed input-to-output latency in cycles. Not overridable; exposed for benches.

Ports:
- clk  in  1  clock; all registers sample on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = requant, 1 = add.
- in_tag  in  TAG_W  opaque tag, carried with the beat.
- As  in  N*27  mode-0 multiplier per lane; bit 26 is always 0.
- Bs  in  N*34  signed mode-0 operand per lane.
- Cs  in  N*34  signed mode-0 bias/offset per lane.
- Ds  in  N*27  mode-1 multiplier per lane; bit 26 is always 0.
- Es  in  N*9  signed mode-1 operand per lane.
- Ss  in  N*6  right-shift amount per lane.
- Zs  in  N*8  output zero point per lane, unsigned.
- outs  out  N*8  uint8 result per lane.
- out_tag  out  TAG_W  tag aligned with outs.

Behaviour:
- Reset
  - rst_n low asynchronously clears all pipeline registers, outs, out_tag and the add-phase bit.
  - Inputs are ignored while rst_n is low.
  - An in-flight beat at reset assertion is discarded, never emitted.
- Pipelining
  - No handshake and no stall; one beat is accepted every cycle.
  - mode, S, Z and tag are pipelined with their beat, so mode may change on any cycle.
- Latency
  - A beat sampled at edge k appears on outs/out_tag after edge k+6.
- Stages
  - S1: register all inputs.
  - S2: mode 0 computes sum = sext35(B) + sext35(C). Mode 1 computes p = E(signed 9) * D(signed 27) as 36 bits.
  - S3: mode 0 computes prod = sum * A as a signed 62-bit product. Mode 1 runs the pair logic below.
  - S4: if S != 0, add 2^(S-1) (round half up toward +inf); if S == 0, add nothing.
  - S5: arithmetic right shift by S. Shifts of 62 or more give 0 or -1 by sign.
  - S6: add zero-extended Z, clamp to [0,255], register to outs and out_tag.
- Mode-1 pair logic (one phase bit, shared by all lanes)
  - phase 0 beat: latch p0 = p. The beat continues with value 0 and tag forced to 0.
  - phase 1 beat: value = sext62(p0 + p), tag = its own in_tag.
  - phase toggles on every mode-1 beat at S3.
  - Any mode-0 beat reaching S3 clears phase to 0.
  - A lone phase-0 beat followed by mode 0 leaves no output beyond its zero-tag slot.
- Width rules
  - No intermediate overflow is possible. Max |B+C| < 2^34; times A < 2^26 gives < 2^60, within 62 bits.
  - Clamping happens only in S6.
- Outputs are registered and hold their last value between beats. Consumers qualify outs using out_tag.

Decomposition:
- Shared package ppu_pkg:
  - lane field widths: 27/34/34/27/9/6/8;
  - TAG_W;
  - LAT = 6;
  - mode encodings PPU_MODE_REQ = 0 and PPU_MODE_ADD = 1.
- One sub-module, ppu_lane: a single lane covering S2–S6 datapath, instantiated N times.
- The top level holds the input register, the phase bit and the tag delay line.

Test Plan:
- Reset and latency: rst_n low with random inputs -> outs = 0, out_tag = 0. Release, then drive a mode-0 beat with tag 0x01 at edge k -> tag appears after edge k+6, zero before it.
- Requant: B = 1000, C = -200, A = 2^20, S = 24, Z = 10, tag 0x01 on all lanes -> every lane outs = 60 (800/16 = 50, plus 10).
- Clamp:
  - B = -100000, C = 0, A = 2^20, S = 20, Z = 5 -> 0.
  - B = +100000 with the same A, S, Z -> 255.
  - Expected value is checked per lane with distinct per-lane B.
- Rounding:
  - B = 3, C = 0, A = 1, S = 1, Z = 0 -> 2.
  - B = -3, Z = 128 -> 127 ((-3 + 1) >> 1 = -1).
  - S = 0, B = 7, A = 1, Z = 0 -> 7.
- Add pair:
  - beat0: E = 10, D = 2^20, tag 0x30. beat1: E = -4, D = 2^21, tag 0x30. Both with S = 20, Z = 100.
  - -> slot0 out_tag = 0, slot1 outs = 102, out_tag = 0x30.
- Interleave and reset mid-flight:
  - Drive mode 0 (tag 0x01), add pair, lone add beat, mode 0 (tag 0x01) -> outputs in order, and the lone beat yields only a zero-tag slot.
  - Then assert rst_n low for 1 cycle with 3 beats in flight -> none of them emerge.

Source files
------------

// File: rtl/ppu_arr_pkg.sv
// Shared widths, latency and mode encodings for the post-processing unit array.
package ppu_pkg;
  localparam int A_W   = 27;
  localparam int B_W   = 34;
  localparam int C_W   = 34;
  localparam int D_W   = 27;
  localparam int E_W   = 9;
  localparam int S_W   = 6;
  localparam int Z_W   = 8;
  localparam int TAG_W = 8;
  localparam int LAT   = 6;

  localparam logic PPU_MODE_REQ = 1'b0;
  localparam logic PPU_MODE_ADD = 1'b1;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic [D_W-1:0] d;
    logic [E_W-1:0] e;
    logic [S_W-1:0] s;
    logic [Z_W-1:0] z;
  } lane_in_t;
endpackage

// File: rtl/ppu_arr_if.sv
// Operand bundle from the array controller and the tagged uint8 result back to it.
interface ppu_arr_if #(
  parameter int N     = 64,
  parameter int TAG_W = ppu_pkg::TAG_W
);
  logic                             mode;
  logic [TAG_W-1:0]                 in_tag;
  logic [N-1:0][ppu_pkg::A_W-1:0]   As;
  logic [N-1:0][ppu_pkg::B_W-1:0]   Bs;
  logic [N-1:0][ppu_pkg::C_W-1:0]   Cs;
  logic [N-1:0][ppu_pkg::D_W-1:0]   Ds;
  logic [N-1:0][ppu_pkg::E_W-1:0]   Es;
  logic [N-1:0][ppu_pkg::S_W-1:0]   Ss;
  logic [N-1:0][ppu_pkg::Z_W-1:0]   Zs;
  logic [N-1:0][7:0]                outs;
  logic [TAG_W-1:0]                 out_tag;

  modport master (output mode, in_tag, As, Bs, Cs, Ds, Es, Ss, Zs,
                  input  outs, out_tag);
  modport slave  (input  mode, in_tag, As, Bs, Cs, Ds, Es, Ss, Zs,
                  output outs, out_tag);
endinterface

// File: rtl/ppu_arr_lane.sv
// One lane, stages S2..S6: scale, optional add-pair combine, round, shift, offset, clamp.
module ppu_lane
  import ppu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic           phase,
  input  lane_in_t       li,
  output logic [Z_W-1:0] res
);
  logic                  m2, m3;
  logic [S_W-1:0]        s2, s3, s4, s5;
  logic [Z_W-1:0]        z2, z3, z4, z5, z6;
  logic [A_W-1:0]        a2;
  logic signed [35:0]    v2, p3, p0;
  logic signed [49:0]    lo3, hi3;
  logic signed [61:0]    v4;
  logic signed [63:0]    v5, v6;

  logic signed [34:0]    sum;
  logic signed [35:0]    p;
  logic signed [49:0]    lo, hi;
  logic signed [61:0]    prod, pair;
  logic [63:0]           rnd;
  logic signed [63:0]    t;

  assign sum  = $signed({li.b[B_W-1], li.b}) + $signed({li.c[C_W-1], li.c});
  assign p    = $signed({{27{li.e[E_W-1]}}, li.e}) * $signed({{9{li.d[D_W-1]}}, li.d});
  // The 35x27 multiply is split on A into two halves, recombined one rank later.
  assign lo   = $signed({{15{v2[34]}}, v2[34:0]}) * $signed({37'd0, a2[12:0]});
  assign hi   = $signed({{15{v2[34]}}, v2[34:0]}) * $signed({36'd0, a2[26:13]});
  assign prod = $signed({{12{lo3[49]}}, lo3}) + ($signed({{12{hi3[49]}}, hi3}) <<< 13);
  assign pair = $signed({{26{p0[35]}}, p0}) + $signed({{26{p3[35]}}, p3});
  assign rnd  = (s4 == '0) ? 64'd0 : (64'd1 << (s4 - 6'd1));
  assign t    = v6 + $signed({56'd0, z6});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 <= 1'b0; m3 <= 1'b0;
      s2 <= '0; s3 <= '0; s4 <= '0; s5 <= '0;
      z2 <= '0; z3 <= '0; z4 <= '0; z5 <= '0; z6 <= '0;
      a2 <= '0; v2 <= '0; p3 <= '0; p0 <= '0;
      lo3 <= '0; hi3 <= '0; v4 <= '0; v5 <= '0; v6 <= '0;
      res <= '0;
    end else begin
      m2 <= mode; s2 <= li.s; z2 <= li.z; a2 <= li.a;
      v2 <= (mode == PPU_MODE_ADD) ? p : {sum[34], sum};

      m3 <= m2; s3 <= s2; z3 <= z2;
      lo3 <= lo; hi3 <= hi; p3 <= v2;

      s4 <= s3; z4 <= z3;
      v4 <= (m3 != PPU_MODE_ADD) ? prod : (phase ? pair : '0);
      if (m3 == PPU_MODE_ADD && !phase) p0 <= p3;

      // Widened to 64 bits so the rounding constant for large shifts never wraps.
      s5 <= s4; z5 <= z4;
      v5 <= $signed({{2{v4[61]}}, v4}) + $signed(rnd);

      z6 <= z5;
      v6 <= v5 >>> s5;

      res <= t[63] ? '0 : (|t[62:8] ? '1 : t[7:0]);
    end
  end
endmodule

// File: rtl/ppu_arr.sv
// PPU array top: input register, add-pair phase bit, tag delay line and N lanes.
module ppu_arr
  import ppu_pkg::*;
#(
  parameter int N = 64
) (
  input logic      clk,
  input logic      rst_n,
  ppu_arr_if.slave bus
);
  lane_in_t [N-1:0]            r1;
  logic     [LAT:0][TAG_W-1:0] tag_p;
  logic     [2:0]              mode_p;
  logic                        phase;
  logic     [N-1:0][7:0]       res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        r1[i] <= {bus.As[i], bus.Bs[i], bus.Cs[i], bus.Ds[i], bus.Es[i], bus.Ss[i], bus.Zs[i]};
    end
  end

  // mode_p[2] and tag_p[2] line up with the lane rank where the pair logic runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p  <= '0;
      mode_p <= '0;
      phase  <= 1'b0;
    end else begin
      mode_p       <= {mode_p[1:0], bus.mode};
      tag_p[0]     <= bus.in_tag;
      tag_p[1]     <= tag_p[0];
      tag_p[2]     <= tag_p[1];
      tag_p[3]     <= (mode_p[2] == PPU_MODE_ADD && !phase) ? '0 : tag_p[2];
      tag_p[LAT:4] <= tag_p[LAT-1:3];
      phase        <= (mode_p[2] == PPU_MODE_ADD) ? ~phase : 1'b0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    ppu_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode_p[0]),
      .phase (phase),
      .li    (r1[g]),
      .res   (res[g])
    );
  end

  assign bus.outs    = res;
  assign bus.out_tag = tag_p[LAT];
endmodule

// File: tb/tb_ppu_arr.sv
// Bench for ppu_arr: directed scenarios against hand-derived constants, random beats against an arithmetic model.
module tb_ppu_arr;
  import ppu_pkg::*;
  localparam int N = 64;

  typedef struct {
    logic             mode;
    logic [7:0]       tag;
    logic [N-1:0][26:0] a;
    logic [N-1:0][33:0] b;
    logic [N-1:0][33:0] c;
    logic [N-1:0][26:0] d;
    logic [N-1:0][8:0]  e;
    logic [N-1:0][5:0]  s;
    logic [N-1:0][7:0]  z;
  } beat_t;

  typedef struct {
    logic [N-1:0][7:0] outs;
    logic [7:0]        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  int   m_phase = 0;
  longint m_p0 [N];

  always #5 clk = ~clk;

  ppu_arr_if #(.N(N)) bus ();
  ppu_arr #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic drive(input beat_t bt);
    bus.mode = bt.mode; bus.in_tag = bt.tag;
    bus.As = bt.a; bus.Bs = bt.b; bus.Cs = bt.c; bus.Ds = bt.d;
    bus.Es = bt.e; bus.Ss = bt.s; bus.Zs = bt.z;
  endtask

  function automatic beat_t uni(input logic m, input logic [7:0] tg, input longint a, b, c, d, e, s, z);
    beat_t bt;
    bt.mode = m; bt.tag = tg;
    for (int i = 0; i < N; i++) begin
      bt.a[i] = 27'(a); bt.b[i] = 34'(b); bt.c[i] = 34'(c); bt.d[i] = 27'(d);
      bt.e[i] = 9'(e);  bt.s[i] = 6'(s);  bt.z[i] = 8'(z);
    end
    return bt;
  endfunction

  function automatic beat_t idle();
    return uni(1'b0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t cexp(input logic [7:0] v, input logic [7:0] tg);
    exp_t e;
    for (int i = 0; i < N; i++) e.outs[i] = v;
    e.tag = tg;
    return e;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t bt;
    bt.mode = 1'($urandom_range(0, 1));
    bt.tag  = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      int k = $urandom_range(0, 2);
      if (k == 0) begin
        bt.a[i] = 27'($urandom_range(0, 67108863));
        bt.b[i] = 34'({$urandom, $urandom});
        bt.c[i] = 34'({$urandom, $urandom});
        bt.d[i] = 27'($urandom_range(0, 67108863));
        bt.s[i] = 6'($urandom_range(34, 63));
      end else begin
        bt.a[i] = 27'($urandom_range(0, 4095));
        bt.b[i] = 34'(longint'($urandom_range(0, 4000)) - 2000);
        bt.c[i] = 34'(longint'($urandom_range(0, 4000)) - 2000);
        bt.d[i] = 27'($urandom_range(0, 4095));
        bt.s[i] = (k == 1) ? 6'($urandom_range(0, 30)) : 6'($urandom);
      end
      bt.e[i] = 9'($urandom);
      bt.z[i] = 8'($urandom);
    end
    return bt;
  endfunction

  // Beat-level reference: exact integer arithmetic plus the pairing rule for add beats.
  task automatic model(input beat_t bt, output exp_t e);
    e.tag = bt.tag;
    for (int i = 0; i < N; i++) begin
      longint v;
      if (bt.mode == 1'b0) begin
        v = (longint'($signed(bt.b[i])) + longint'($signed(bt.c[i]))) * longint'(bt.a[i]);
      end else begin
        longint pp = longint'($signed(bt.e[i])) * longint'(bt.d[i]);
        if (m_phase == 0) begin m_p0[i] = pp; v = 0; end
        else v = m_p0[i] + pp;
      end
      if (bt.s[i] != 0) v = v + (longint'(1) << (bt.s[i] - 1));
      v = v >>> bt.s[i];
      v = v + longint'(bt.z[i]);
      e.outs[i] = (v < 0) ? 8'd0 : ((v > 255) ? 8'hFF : 8'(v));
    end
    if (bt.mode == 1'b1) begin
      if (m_phase == 0) e.tag = 8'h00;
      m_phase = 1 - m_phase;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic test_reset();
    exp_t ce = cexp(8'd60, 8'h01);
    rst_n = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      drive(rnd_beat());
      vecs++; if (bus.outs !== '0) begin errs++; $display("FAIL reset_outs cyc %0d: got %h want 0", j, bus.outs); end
      vecs++; if (bus.out_tag !== 8'h00) begin errs++; $display("FAIL reset_tag cyc %0d: got %h want 00", j, bus.out_tag); end
    end
    @(negedge clk); drive(idle()); rst_n = 1'b1;
    @(negedge clk); drive(uni(1'b0, 8'h01, 1 << 20, 1000, -200, 0, 0, 24, 10));
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clk);
      vecs++;
      if (bus.out_tag !== ((j == LAT + 1) ? 8'h01 : 8'h00)) begin
        errs++; $display("FAIL latency_tag after %0d edges: got %h", j - 1, bus.out_tag);
      end
      if (j == LAT + 1) begin
        vecs++; if (bus.outs !== ce.outs) begin errs++; $display("FAIL latency_outs: got %h want %h", bus.outs, ce.outs); end
      end
      drive(idle());
    end
    repeat (LAT) @(negedge clk);
  endtask

  task automatic test_requant();
    beat_t bq[$]; exp_t eq[$];
    bq.push_back(uni(1'b0, 8'h01, 1 << 20, 1000, -200, 0, 0, 24, 10)); eq.push_back(cexp(8'd60, 8'h01));
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL requant_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL requant_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
  endtask

  task automatic test_clamp();
    beat_t bq[$]; exp_t eq[$];
    beat_t bn = uni(1'b0, 8'h11, 1 << 20, 0, 0, 0, 0, 20, 5);
    beat_t bp = bn, bm = bn;
    exp_t  em;
    bp.tag = 8'h12; bm.tag = 8'h13; em.tag = 8'h13;
    for (int i = 0; i < N; i++) begin
      int v = i * 5 - 55;
      bn.b[i] = 34'(-(100000 + i * 13));
      bp.b[i] = 34'(100000 + i * 13);
      bm.b[i] = 34'(i * 5 - 60);
      em.outs[i] = (v < 0) ? 8'd0 : ((v > 255) ? 8'd255 : 8'(v));
    end
    bq.push_back(bn); eq.push_back(cexp(8'd0, 8'h11));
    bq.push_back(bp); eq.push_back(cexp(8'd255, 8'h12));
    bq.push_back(bm); eq.push_back(em);
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL clamp_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL clamp_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
  endtask

  task automatic test_round();
    beat_t bq[$]; exp_t eq[$];
    bq.push_back(uni(1'b0, 8'h21, 1, 3, 0, 0, 0, 1, 0));    eq.push_back(cexp(8'd2, 8'h21));
    bq.push_back(uni(1'b0, 8'h22, 1, -3, 0, 0, 0, 1, 128)); eq.push_back(cexp(8'd127, 8'h22));
    bq.push_back(uni(1'b0, 8'h23, 1, 7, 0, 0, 0, 0, 0));    eq.push_back(cexp(8'd7, 8'h23));
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL round_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL round_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
  endtask

  task automatic test_add_pair();
    beat_t bq[$]; exp_t eq[$];
    bq.push_back(uni(1'b1, 8'h30, 0, 0, 0, 1 << 20, 10, 20, 100)); eq.push_back(cexp(8'd100, 8'h00));
    bq.push_back(uni(1'b1, 8'h30, 0, 0, 0, 1 << 21, -4, 20, 100)); eq.push_back(cexp(8'd102, 8'h30));
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL add_pair_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL add_pair_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
  endtask

  task automatic test_interleave();
    beat_t bq[$]; exp_t eq[$];
    bq.push_back(uni(1'b0, 8'h01, 1 << 20, 1000, -200, 0, 0, 24, 10)); eq.push_back(cexp(8'd60, 8'h01));
    bq.push_back(uni(1'b1, 8'h30, 0, 0, 0, 1 << 20, 10, 20, 100));     eq.push_back(cexp(8'd100, 8'h00));
    bq.push_back(uni(1'b1, 8'h30, 0, 0, 0, 1 << 21, -4, 20, 100));     eq.push_back(cexp(8'd102, 8'h30));
    bq.push_back(uni(1'b1, 8'h55, 0, 0, 0, 1 << 20, 5, 20, 100));      eq.push_back(cexp(8'd100, 8'h00));
    bq.push_back(uni(1'b0, 8'h01, 1 << 20, 1000, -200, 0, 0, 24, 10)); eq.push_back(cexp(8'd60, 8'h01));
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL interleave_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL interleave_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); drive(uni(1'b0, 8'h77, 1 << 20, 1000, -200, 0, 0, 24, 10));
    end
    @(negedge clk); drive(idle()); rst_n = 1'b0;
    #1;
    vecs++; if (bus.outs !== '0 || bus.out_tag !== 8'h00) begin errs++; $display("FAIL midreset_clear: got tag %h outs %h want 0", bus.out_tag, bus.outs); end
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < LAT + 4; j++) begin
      @(negedge clk);
      vecs++; if (bus.out_tag !== 8'h00) begin errs++; $display("FAIL midreset_tag cyc %0d: got %h want 00", j, bus.out_tag); end
      vecs++; if (bus.outs !== '0) begin errs++; $display("FAIL midreset_outs cyc %0d: got %h want 0", j, bus.outs); end
    end
  endtask

  task automatic test_random();
    beat_t bq[$]; exp_t eq[$];
    m_phase = 0;
    for (int n = 0; n < 400; n++) begin
      beat_t bt = rnd_beat();
      exp_t  e;
      model(bt, e);
      bq.push_back(bt); eq.push_back(e);
    end
    for (int c = 0; c < bq.size() + LAT + 1; c++) begin
      @(negedge clk);
      if (c > LAT) begin
        vecs++; if (bus.out_tag !== eq[c-LAT-1].tag) begin errs++; $display("FAIL random_tag slot %0d: got %h want %h", c-LAT-1, bus.out_tag, eq[c-LAT-1].tag); end
        vecs++; if (bus.outs !== eq[c-LAT-1].outs) begin errs++; $display("FAIL random_outs slot %0d: got %h want %h", c-LAT-1, bus.outs, eq[c-LAT-1].outs); end
      end
      if (c < bq.size()) drive(bq[c]); else drive(idle());
    end
  endtask

  initial begin
    drive(idle());
    test_reset();
    test_requant();
    test_clamp();
    test_round();
    test_add_pair();
    test_interleave();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
